xc_aessub_mc: RTL and testbench
===============================

# xc_aessub_mc

Multi-cycle, parametrised AES sub-bytes functional unit for the `xc.aessub.{enc,dec,encrot,decrot}` instruction family. It sits in the execute stage next to the ALU and replaces the single-cycle, four-S-box combinational evaluator with a lane-configurable iterative datapath. The datapath trades area (1, 2 or 4 S-box instances) against latency. It uses a valid/ready handshake and supports abort and flush.

## Interface

Parameters:
- `LANES`, default 1: number of S-box instances; legal values are 1, 2 and 4.
- `RESULT_HOLD`, default 0: if 1, `result` keeps its last value after `ready`; if 0, `result` reads 0 whenever `ready` is low.

Ports:
- `g_clk` in 1: core clock.
- `g_resetn` in 1: reset, asynchronous assert, active low.
- `flush` in 1: pipeline flush. Aborts any operation in progress.
- `valid` in 1: request. Held high until `ready` is seen.
- `rs1` in 32: source register 1.
- `rs2` in 32: source register 2.
- `enc` in 1: 1 selects the forward S-box, 0 selects the inverse S-box.
- `rot` in 1: 1 rotates the result left by 8 bits.
- `ready` out 1: one-cycle pulse; `result` is valid in this cycle.
- `result` out 32: instruction result.

## Operation

- **Byte selection.** t = {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]}.
- **Substitution.** s[i] = enc ? SBOX(t[i]) : INV_SBOX(t[i]), for i = 0..3.
- **Result.** result = rot ? {s[2],s[1],s[0],s[3]} : {s[3],s[2],s[1],s[0]}.
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE.**
  - If `valid` && !`flush`: latch t (32 b), `enc` and `rot`; clear the byte counter `cnt` and the accumulator `acc`; go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY.**
  - Each cycle, lanes 0..LANES-1 substitute bytes `cnt*LANES + l` of the latched t and write them into `acc`.
  - `cnt` is log2(4/LANES) bits wide and increments by 1.
  - When `cnt` == 4/LANES-1, the final write happens and the next state is DONE.
- **DONE.**
  - `ready` = 1 and `result` = the rotation-adjusted `acc`.
  - The next state is unconditionally IDLE.
- **Operand sampling.** Operands, `enc` and `rot` are sampled only at acceptance. Changes to them during BUSY are ignored.
- **Abort.** If `valid` falls while in BUSY, go to IDLE at the next edge. `ready` is never asserted for that operation, and `acc` is discarded.
- **Flush.** `flush` has top priority in every state: the next state is IDLE and `ready` is forced to 0 in the same cycle, even in DONE.
- **Back-to-back.** If `valid` is still high in the cycle after DONE, that cycle is IDLE, so a new operation is accepted then. This gives back-to-back throughput of one result per 4/LANES+2 cycles.
- **Reset.** Asynchronous reset to state IDLE, `cnt`=0, `acc`=0, `ready`=0, `result`=0. An assertion during BUSY or DONE abandons the operation with no `ready` pulse.
- **`result` when `ready` is low.**
  - With RESULT_HOLD=0, `result` is 0 whenever `ready` is low.
  - With RESULT_HOLD=1, `result` is registered at DONE and retained until the next DONE or reset.

## Timing

- **Latency.** With `valid` accepted at edge 0, `ready` is high in cycle 4/LANES+1:
  - LANES=1: cycle 5.
  - LANES=2: cycle 3.
  - LANES=4: cycle 2.
- **`ready` pulse.** `ready` is high for exactly one cycle per completed operation.
- **Combinational paths.** No combinational path exists from any input to `ready`, except `flush` forcing `ready` low.
- **Critical path.** The critical path is one S-box plus the `acc` write mux. The inputs `rs1`/`rs2` are registered at acceptance, so there is no input-to-S-box path.

## Structure

- **Package `xc_aessub_pkg`:**
  - FSM state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Function `clog2`.
  - Constant `XC_AES_BYTES` = 4.
  - Byte-select helper.
- **Sub-module `xc_aes_sbox`:** combinational 8-bit forward/inverse S-box with `enc` select, instantiated LANES times in a generate loop.
- **Top level:** the top contains only the FSM, the counter, the operand/accumulator registers and the output rotate.

## Test plan

- **Encrypt, per LANES.** For each LANES in {1,2,4}: rs1=0x00010053, rs2=0x00000000, enc=1, rot=0 -> `result`=0x637C63ED with `ready` at cycle 5/3/2 respectively.
- **Encrypt with rotate.** Same operands with rot=1 -> `result`=0x7C63ED63.
- **Decrypt.** rs1=0x00000063, rs2=0x00000000, enc=0, rot=0 -> `result`=0x52525200. Change `rs1` mid-BUSY to 0xFFFFFFFF -> `result` is unchanged.
- **Abort.** LANES=1: drop `valid` in BUSY cycle 2 -> no `ready`. Reassert `valid` with rs1=rs2=0, enc=1 -> `result`=0x63636363 after the full latency.
- **Flush in DONE.** `flush` asserted in the DONE cycle -> `ready`=0, state returns to IDLE, and no stale `result` is visible when RESULT_HOLD=0.
- **Reset in BUSY.** Assert `g_resetn`=0 asynchronously mid-BUSY -> `ready` and `result` are 0 immediately, state is IDLE, and the next operation completes correctly.

Source files
------------

// File: rtl/xc_aessub_pkg.sv
// Shared definitions for the iterative AES sub-bytes unit.
package xc_aessub_pkg;

    localparam int unsigned XC_AES_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Gather the four operand bytes: odd bytes from rs2, even bytes from rs1.
    function automatic logic [31:0] byte_sel(input logic [31:0] a, input logic [31:0] b);
        return {b[31:24], a[23:16], b[15:8], a[7:0]};
    endfunction

endpackage

// File: rtl/xc_aes_sbox.sv
// Combinational AES S-box, forward or inverse, computed in GF(2^8).
module xc_aes_sbox (
    input  logic       enc_i,
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    // Select direction; each path is one inversion plus one affine map.
    always_comb begin
        byte_o = enc_i ? aff_fwd(gf_inv(byte_i)) : gf_inv(aff_inv(byte_i));
    end

endmodule

// File: rtl/xc_aessub_mc.sv
// Iterative AES sub-bytes unit: LANES S-boxes process the word over 4/LANES cycles.
module xc_aessub_mc #(
    parameter int unsigned LANES       = 1,
    parameter int unsigned RESULT_HOLD = 0
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    output logic        ready,
    output logic [31:0] result
);

    import xc_aessub_pkg::*;

    localparam int unsigned STEPS = XC_AES_BYTES / LANES;
    localparam int unsigned CNT_W = (STEPS > 1) ? clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      t_q, t_d;
    logic [31:0]      acc_q, acc_d;
    logic             enc_q, enc_d;
    logic             rot_q, rot_d;

    logic [1:0]       lane_idx [LANES];
    logic [7:0]       sb_in    [LANES];
    logic [7:0]       sb_out   [LANES];

    logic             done_c;
    logic [31:0]      rot_res_c;

    // One S-box per lane, each reading its byte of the latched operand.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_idx[g] = 2'(32'(cnt_q) * LANES + 32'(g));
        assign sb_in[g]    = t_q[{lane_idx[g], 3'b000} +: 8];

        xc_aes_sbox u_sbox (
            .enc_i  (enc_q),
            .byte_i (sb_in[g]),
            .byte_o (sb_out[g])
        );
    end

    // State and datapath registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            t_q     <= '0;
            acc_q   <= '0;
            enc_q   <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            enc_q   <= enc_d;
            rot_q   <= rot_d;
        end
    end

    // Next state: accept, iterate over byte groups, finish; flush overrides all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        acc_d   = acc_q;
        enc_d   = enc_q;
        rot_d   = rot_q;

        case (state_q)
            ST_IDLE: begin
                if (valid && !flush) begin
                    t_d     = byte_sel(rs1, rs2);
                    enc_d   = enc;
                    rot_d   = rot;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!valid) begin
                    state_d = ST_IDLE;
                end else begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        acc_d[{lane_idx[l], 3'b000} +: 8] = sb_out[l];
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // Result strobe comes straight from the state register; only flush can mask it.
    assign done_c    = (state_q == ST_DONE) && !flush;
    assign ready     = done_c;
    assign rot_res_c = rot_q ? {acc_q[23:0], acc_q[31:24]} : acc_q;

    if (RESULT_HOLD != 0) begin : g_hold
        logic [31:0] hold_q;

        // Capture each completed result so it stays visible between operations.
        always_ff @(posedge g_clk or negedge g_resetn) begin
            if (!g_resetn) begin
                hold_q <= '0;
            end else if (done_c) begin
                hold_q <= rot_res_c;
            end
        end

        assign result = done_c ? rot_res_c : hold_q;
    end else begin : g_nohold
        assign result = done_c ? rot_res_c : 32'd0;
    end

endmodule

// File: tb/tb_xc_aessub_mc.sv
// Bench for xc_aessub_mc: LANES=1/2/4 units plus a RESULT_HOLD=1 unit, scoreboard-checked.
module tb_xc_aessub_mc;

    logic        clk;
    logic        g_resetn;
    logic        flush;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        rot;
    logic [3:0]  valid_v;
    logic [3:0]  ready_v;
    logic [31:0] res_v [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          d;
        logic [31:0] exp;
        int          lat;
    } exp_t;

    exp_t sb[$];

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    xc_aessub_mc #(.LANES(1), .RESULT_HOLD(0)) u_l1 (
        .g_clk(clk), .g_resetn(g_resetn), .flush(flush), .valid(valid_v[0]),
        .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot), .ready(ready_v[0]), .result(res_v[0]));
    xc_aessub_mc #(.LANES(2), .RESULT_HOLD(0)) u_l2 (
        .g_clk(clk), .g_resetn(g_resetn), .flush(flush), .valid(valid_v[1]),
        .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot), .ready(ready_v[1]), .result(res_v[1]));
    xc_aessub_mc #(.LANES(4), .RESULT_HOLD(0)) u_l4 (
        .g_clk(clk), .g_resetn(g_resetn), .flush(flush), .valid(valid_v[2]),
        .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot), .ready(ready_v[2]), .result(res_v[2]));
    xc_aessub_mc #(.LANES(1), .RESULT_HOLD(1)) u_h1 (
        .g_clk(clk), .g_resetn(g_resetn), .flush(flush), .valid(valid_v[3]),
        .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot), .ready(ready_v[3]), .result(res_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something unforeseen stalls the sequence.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lanes_of(input int d);
        return (d == 1) ? 2 : (d == 2) ? 4 : 1;
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] sh;
        p  = 8'h00;
        sh = b;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) p = p ^ sh;
            sh = sh[7] ? ((sh << 1) ^ 8'h1B) : (sh << 1);
        end
        return p;
    endfunction

    // Reference tables: brute-force inverse, bitwise affine map, inverse by table lookup.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] f;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                f[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ c[i];
            end
            fwd_tab[x] = f;
            inv_tab[f] = 8'(x);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic e, input logic r);
        logic [31:0] t;
        logic [31:0] s;
        t = {b[31:24], a[23:16], b[15:8], a[7:0]};
        for (int i = 0; i < 4; i++) begin
            s[8*i +: 8] = e ? fwd_tab[t[8*i +: 8]] : inv_tab[t[8*i +: 8]];
        end
        return r ? {s[23:0], s[31:24]} : s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive an operation on unit d (called just after a falling edge) and record expectation.
    task automatic start_op(input int d, input logic [31:0] a, input logic [31:0] b,
                            input logic e, input logic r, input logic [31:0] exp, input int lat);
        exp_t x;
        rs1 = a;
        rs2 = b;
        enc = e;
        rot = r;
        valid_v[d] = 1'b1;
        x.d   = d;
        x.exp = exp;
        x.lat = lat;
        sb.push_back(x);
    endtask

    // Wait (bounded) for ready on the unit of the oldest expectation and compare.
    task automatic wait_ready(input int scramble_cyc, input bit keep);
        exp_t x;
        int   cyc;
        bit   seen;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        x    = sb.pop_front();
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 20 && !seen) begin
            @(negedge clk);
            cyc++;
            if (ready_v[x.d]) begin
                seen = 1'b1;
            end else if (cyc == scramble_cyc) begin
                rs1 = 32'hFFFF_FFFF;
                rs2 = 32'hFFFF_FFFF;
                enc = ~enc;
                rot = ~rot;
            end
        end
        check("ready_seen", 32'(seen), 32'd1);
        check("latency", 32'(cyc), 32'(x.lat));
        check("result", res_v[x.d], x.exp);
        if (!keep) begin
            valid_v[x.d] = 1'b0;
            @(negedge clk);
            check("ready_one_cycle", 32'(ready_v[x.d]), 32'd0);
            check("result_after", res_v[x.d], (x.d == 3) ? x.exp : 32'd0);
        end
    endtask

    initial begin
        bit          seen;
        logic [31:0] a, b, ex;
        logic        e, r;

        build_tables();
        g_resetn = 1'b1;
        flush    = 1'b0;
        valid_v  = 4'b0000;
        rs1 = '0; rs2 = '0; enc = 1'b0; rot = 1'b0;

        // Reset state
        #2 g_resetn = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            check("reset_ready", 32'(ready_v[d]), 32'd0);
            check("reset_result", res_v[d], 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        g_resetn = 1'b1;
        @(negedge clk);

        // Encrypt and encrypt-with-rotate on every lane count, plus the hold unit
        for (int d = 0; d < 4; d++) begin
            start_op(d, 32'h0001_0053, 32'h0, 1'b1, 1'b0, 32'h637C_63ED, 4 / lanes_of(d) + 1);
            wait_ready(0, 1'b0);
            start_op(d, 32'h0001_0053, 32'h0, 1'b1, 1'b1, 32'h7C63_ED63, 4 / lanes_of(d) + 1);
            wait_ready(0, 1'b0);
        end

        // Decrypt with operands scrambled mid-operation
        start_op(0, 32'h0000_0063, 32'h0, 1'b0, 1'b0, 32'h5252_5200, 5);
        wait_ready(2, 1'b0);
        start_op(2, 32'h0000_0063, 32'h0, 1'b0, 1'b0, 32'h5252_5200, 2);
        wait_ready(1, 1'b0);

        // Abort: drop valid in the second busy cycle
        rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0; enc = 1'b1; rot = 1'b0;
        valid_v[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        valid_v[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready_v[0] || res_v[0] != 32'd0) seen = 1'b1;
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        start_op(0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h6363_6363, 5);
        wait_ready(0, 1'b0);

        // Flush in the DONE cycle
        rs1 = 32'h0001_0053; rs2 = 32'h0; enc = 1'b1; rot = 1'b0;
        valid_v[0] = 1'b1;
        valid_v[3] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("flush_pre_ready", 32'(ready_v[0]), 32'd1);
        flush = 1'b1;
        #1;
        check("flush_ready_l1", 32'(ready_v[0]), 32'd0);
        check("flush_ready_hold", 32'(ready_v[3]), 32'd0);
        check("flush_result_l1", res_v[0], 32'd0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        valid_v = 4'b0000;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready_v[0] || ready_v[3]) seen = 1'b1;
        end
        check("flush_no_late_ready", 32'(seen), 32'd0);

        // Asynchronous reset mid-operation
        rs1 = 32'hDEAD_BEEF; rs2 = 32'hCAFE_F00D; enc = 1'b0; rot = 1'b1;
        valid_v[0] = 1'b1;
        valid_v[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 g_resetn = 1'b0;
        #1;
        check("rst_busy_ready", 32'(ready_v[0]), 32'd0);
        check("rst_busy_result", res_v[0], 32'd0);
        check("rst_busy_hold_result", res_v[3], 32'd0);
        valid_v = 4'b0000;
        @(negedge clk);
        g_resetn = 1'b1;
        @(negedge clk);
        start_op(0, 32'h0001_0053, 32'h0, 1'b1, 1'b1, 32'h7C63_ED63, 5);
        wait_ready(0, 1'b0);

        // Back-to-back on LANES=2: valid stays high across two operations
        a = 32'h0011_2233; b = 32'h4455_6677;
        start_op(1, a, b, 1'b1, 1'b0, model(a, b, 1'b1, 1'b0), 3);
        wait_ready(0, 1'b1);
        a = 32'h8899_AABB; b = 32'hCCDD_EEFF;
        start_op(1, a, b, 1'b0, 1'b1, model(a, b, 1'b0, 1'b1), 4);
        wait_ready(0, 1'b0);

        // Random operations against the reference model
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 4; k++) begin
                a  = $urandom;
                b  = $urandom;
                e  = 1'($urandom_range(0, 1));
                r  = 1'($urandom_range(0, 1));
                ex = model(a, b, e, r);
                start_op(d, a, b, e, r, ex, 4 / lanes_of(d) + 1);
                wait_ready(0, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
